// File: rtl/bk_limb_add_seq.sv
// bk_limb_add_seq: multi-limb add sequencer around a 16-bit Brent-Kung adder.
//   Operands of 16*WORDS bits are accepted over in_valid/in_ready. The block
//   then feeds the external adder one 16-bit limb per cycle, LSB limb first,
//   and chains each limb's carry into the next. The result is returned over
//   out_valid/out_ready.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready       result handshake (out_sum, out_cout)
//   add_a/add_b/add_cin       limb operands to the adder
//   add_sum/add_cout          limb result from the adder
// BrentKung16bit (same file) is the combinational adder that is wired beside
// the sequencer at the next level up.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | one limb per cycle through the adder, idx selects the limb
// DONE  | result held until the consumer takes it

module bk_limb_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_sum,
  input  logic                  add_cout
);

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic            cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]   idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opa_d   = in_a;
          opb_d   = in_b;
          cin_d   = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = opa_q[16*idx_q +: 16];
        add_b   = opb_q[16*idx_q +: 16];
        // limb 0 takes the external carry, later limbs the chained one
        add_cin = (idx_q == '0) ? cin_q : carry_q;
        res_d[16*idx_q +: 16] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // outputs read as idle-zero while reset is held
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
    end
  end

  assign out_sum  = res_q;
  assign out_cout = cout_q;

endmodule

// BrentKung16bit: 16-bit parallel-prefix adder (Brent-Kung tree).
//   a, b   addends; Cin carry-in; Sum result; Cout carry-out.
module BrentKung16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);

  logic [15:0] p, g, gp, pp;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = g;
    pp = p;
    // fold the carry-in into bit 0 so every prefix already includes it
    gp[0] = g[0] | (p[0] & Cin);
    // up-sweep: group (g,p) over aligned power-of-two spans
    for (int l = 0; l < 4; l++) begin
      for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
        gp[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    // down-sweep: fill in the remaining prefixes
    for (int l = 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < 16; i += (2 << l)) begin
        gp[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
      end
    end
    Sum  = p ^ {gp[14:0], Cin};
    Cout = gp[15];
  end

endmodule

// File: tb/tb_bk_limb_add_seq.sv
module tb_bk_limb_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WORDS = 4 instance
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [63:0] in_a, in_b, out_sum;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  bk_limb_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  BrentKung16bit u_add (
    .a(add_a), .b(add_b), .Cin(add_cin), .Sum(add_sum), .Cout(add_cout)
  );

  // WORDS = 2 instance
  logic        s2_in_valid, s2_in_ready, s2_in_cin, s2_out_valid, s2_out_ready, s2_out_cout;
  logic [31:0] s2_in_a, s2_in_b, s2_out_sum;
  logic [15:0] s2_add_a, s2_add_b, s2_add_sum;
  logic        s2_add_cin, s2_add_cout;

  bk_limb_add_seq #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(s2_in_valid), .in_ready(s2_in_ready),
    .in_a(s2_in_a), .in_b(s2_in_b), .in_cin(s2_in_cin),
    .out_valid(s2_out_valid), .out_ready(s2_out_ready),
    .out_sum(s2_out_sum), .out_cout(s2_out_cout),
    .add_a(s2_add_a), .add_b(s2_add_b), .add_cin(s2_add_cin),
    .add_sum(s2_add_sum), .add_cout(s2_add_cout)
  );

  BrentKung16bit u_add2 (
    .a(s2_add_a), .b(s2_add_b), .Cin(s2_add_cin), .Sum(s2_add_sum), .Cout(s2_add_cout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, wait for acceptance and result, consume it.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                       output logic [63:0] s, output logic co, output int lat);
    int n;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    s = out_sum; co = out_cout;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] s, a, b;
    logic [64:0] ref65;
    logic [32:0] ref33;
    logic [31:0] a2, b2;
    logic        co, c;
    int          lat, n, last_acc, acc;

    vecs[0] = '{64'd22, 64'd53, 1'b0, 64'd75, 1'b0};
    vecs[1] = '{64'd35, 64'd42, 1'b1, 64'd78, 1'b0};
    vecs[2] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    vecs[3] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    s2_in_valid = 1'b0; s2_in_a = '0; s2_in_b = '0; s2_in_cin = 1'b0; s2_out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_add_a", {add_a, add_b, add_cin}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // table-driven vectors
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].co);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_add_idle", i), {add_a, add_b, add_cin}, 0);
    end

    // backpressure: hold result while new operands wait on in_valid
    in_a = 64'h0001_0002_0003_0004; in_b = 64'h0010_0020_0030_0040; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_a = 64'd100; in_b = 64'd200; in_cin = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 64'h0011_0022_0033_0044);
      chk("bp_cout", out_cout, 0);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("bp_new_sum", out_sum, 64'd300);
    chk("bp_new_latency", lat, 4);
    @(posedge clk); #1;

    // reset in the middle of RUN at idx 2
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_cin = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("mid_rst_no_emit", n, 0);
    do_op(64'd645, 64'd246, 1'b0, s, co, lat);
    chk("after_rst_sum", {co, s}, 65'd891);

    // streaming, WORDS = 4
    out_ready = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      c = 1'($urandom_range(0, 1));
      ref65 = {1'b0, a} + {1'b0, b} + {64'd0, c};
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      acc = cyc;
      if (i > 0) chk($sformatf("stream4_period%0d", i), acc - last_acc, 6);
      last_acc = acc;
      @(posedge clk); #1;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk($sformatf("stream4_res%0d", i), {out_cout, out_sum}, ref65);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // streaming, WORDS = 2
    s2_out_ready = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 20; i++) begin
      a2 = $urandom();
      b2 = $urandom();
      if (i == 0) begin a2 = 32'hFFFF_FFFF; b2 = 32'hFFFF_FFFF; end
      c = 1'($urandom_range(0, 1));
      ref33 = {1'b0, a2} + {1'b0, b2} + {32'd0, c};
      s2_in_a = a2; s2_in_b = b2; s2_in_cin = c; s2_in_valid = 1'b1;
      n = 0;
      while (!s2_in_ready && n < 50) begin @(posedge clk); #1; n++; end
      acc = cyc;
      if (i > 0) chk($sformatf("stream2_period%0d", i), acc - last_acc, 4);
      last_acc = acc;
      @(posedge clk); #1;
      n = 0;
      while (!s2_out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk($sformatf("stream2_res%0d", i), {s2_out_cout, s2_out_sum}, ref33);
    end
    s2_in_valid = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
